// File: rtl/vending_multi_pkg.sv
// Shared state type, coin values and pricing helpers for the multi-product vending controller.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } vend_state_e;

   localparam int HALF_VAL = 1;
   localparam int ONE_VAL  = 2;

   function automatic int price(input int idx, input int base, input int step);
      return base + idx * step;
   endfunction

   function automatic int sel_width(input int num_items);
      return (num_items > 1) ? $clog2(num_items) : 1;
   endfunction

endpackage

// File: rtl/vending_multi_if.sv
// Front-end / driver-side signal bundle of the vending controller; master drives coins and keys.
interface vending_multi_if #(
   parameter int NUM_ITEMS = 4,
   parameter int CREDIT_W  = 5
);
   import vending_pkg::*;

   localparam int SEL_W = sel_width(NUM_ITEMS);

   logic                 half;
   logic                 one;
   logic [SEL_W-1:0]     sel;
   logic                 sel_valid;
   logic                 cancel;
   logic                 restock;
   logic                 bev;
   logic [SEL_W-1:0]     item;
   logic [CREDIT_W-1:0]  bal;
   logic                 coin_rej;
   logic                 deny;
   logic                 chg_one;
   logic                 chg_half;
   logic [NUM_ITEMS-1:0] sold_out;

   modport master (
      output half, one, sel, sel_valid, cancel, restock,
      input  bev, item, bal, coin_rej, deny, chg_one, chg_half, sold_out
   );

   modport slave (
      input  half, one, sel, sel_valid, cancel, restock,
      output bev, item, bal, coin_rej, deny, chg_one, chg_half, sold_out
   );

endinterface

// File: rtl/vending_multi_change.sv
// Change dispenser: one coin per active cycle (one-unit first, then a final half-unit),
// returning the remaining credit and a done flag to the controller.
module vending_change
   import vending_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_active,
   input  logic [CREDIT_W-1:0] i_credit,
   output logic [CREDIT_W-1:0] o_credit_next,
   output logic                o_done,
   output logic                o_chg_one,
   output logic                o_chg_half
);

   logic w_one;
   logic w_half;
   logic r_chg_one;
   logic r_chg_half;

   // Choose the coin for this cycle and the credit left afterwards
   always_comb begin
      w_one         = 1'b0;
      w_half        = 1'b0;
      o_credit_next = i_credit;
      if (i_active) begin
         if (i_credit >= CREDIT_W'(ONE_VAL)) begin
            w_one         = 1'b1;
            o_credit_next = i_credit - CREDIT_W'(ONE_VAL);
         end else if (i_credit == CREDIT_W'(HALF_VAL)) begin
            w_half        = 1'b1;
            o_credit_next = {CREDIT_W{1'b0}};
         end else begin
            o_credit_next = i_credit;
         end
      end else begin
         o_credit_next = i_credit;
      end
   end

   assign o_done = (o_credit_next == {CREDIT_W{1'b0}});

   // Register the hopper pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_chg_one  <= 1'b0;
         r_chg_half <= 1'b0;
      end else begin
         r_chg_one  <= w_one;
         r_chg_half <= w_half;
      end
   end

   assign o_chg_one  = r_chg_one;
   assign o_chg_half = r_chg_half;

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: credit accumulation, priced vend, change and refund.
// Optional per-item stock tracking is enabled with the VENDING_STOCK_EN macro.
module vending_multi
   import vending_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20,
   parameter int PRICE_BASE = 3,
   parameter int PRICE_STEP = 1,
   parameter int STOCK_INIT = 5
) (
   input logic            clk,
   input logic            reset,
   vending_multi_if.slave bus
);

   localparam int SEL_W = sel_width(NUM_ITEMS);
   localparam int EXT_W = CREDIT_W + 1;

   vend_state_e          r_state;
   vend_state_e          w_state_next;
   logic [CREDIT_W-1:0]  r_credit;
   logic [CREDIT_W-1:0]  w_credit_next;
   logic [SEL_W-1:0]     r_item;
   logic [SEL_W-1:0]     w_item_next;
   logic                 r_bev;
   logic                 r_coin_rej;
   logic                 r_deny;
   logic                 w_bev;
   logic                 w_coin_rej;
   logic                 w_deny;
   logic                 w_vend_ok;
   logic                 w_chg_active;
   logic                 w_chg_done;
   logic [CREDIT_W-1:0]  w_chg_credit;
   logic [EXT_W-1:0]     w_coin_val;
   logic [EXT_W-1:0]     w_credit_ext;
   logic [EXT_W-1:0]     w_coin_sum;
   logic [EXT_W-1:0]     w_price;
   logic                 w_coin_any;
   logic                 w_sel_in_range;
   logic                 w_sel_sold;
   logic                 w_sel_ok;
   logic [NUM_ITEMS-1:0] w_sold_out;

   assign w_coin_any     = bus.half | bus.one;
   assign w_coin_val     = (bus.half ? EXT_W'(HALF_VAL) : {EXT_W{1'b0}})
                         + (bus.one  ? EXT_W'(ONE_VAL)  : {EXT_W{1'b0}});
   assign w_credit_ext   = {1'b0, r_credit};
   assign w_coin_sum     = w_credit_ext + w_coin_val;
   assign w_price        = EXT_W'(price(int'(bus.sel), PRICE_BASE, PRICE_STEP));
   assign w_sel_in_range = ({1'b0, bus.sel} < (SEL_W + 1)'(NUM_ITEMS));
   assign w_sel_ok       = w_sel_in_range && !w_sel_sold && (w_credit_ext >= w_price);

   // Next state, credit and response pulses
   always_comb begin
      w_state_next  = r_state;
      w_credit_next = r_credit;
      w_item_next   = r_item;
      w_bev         = 1'b0;
      w_coin_rej    = 1'b0;
      w_deny        = 1'b0;
      w_vend_ok     = 1'b0;
      w_chg_active  = 1'b0;
      case (r_state)
         IDLE, ACCUM: begin
            if (bus.cancel) begin
               w_coin_rej = w_coin_any;
               if (r_credit != {CREDIT_W{1'b0}}) begin
                  w_state_next = CHANGE;
               end else begin
                  w_state_next = r_state;
               end
            end else if (bus.sel_valid) begin
               w_coin_rej = w_coin_any;
               if (w_sel_ok) begin
                  w_state_next  = VEND;
                  w_credit_next = CREDIT_W'(w_credit_ext - w_price);
                  w_item_next   = bus.sel;
                  w_bev         = 1'b1;
                  w_vend_ok     = 1'b1;
               end else begin
                  w_deny = 1'b1;
               end
            end else if (w_coin_any) begin
               if (w_coin_sum <= EXT_W'(MAX_CREDIT)) begin
                  w_credit_next = w_coin_sum[CREDIT_W-1:0];
                  w_state_next  = ACCUM;
               end else begin
                  w_coin_rej = 1'b1;
               end
            end else begin
               w_state_next = r_state;
            end
         end
         VEND: begin
            w_coin_rej = w_coin_any;
            w_deny     = bus.sel_valid;
            if (r_credit != {CREDIT_W{1'b0}}) begin
               w_state_next = CHANGE;
            end else begin
               w_state_next = IDLE;
            end
         end
         CHANGE: begin
            w_coin_rej    = w_coin_any;
            w_deny        = bus.sel_valid;
            w_chg_active  = 1'b1;
            w_credit_next = w_chg_credit;
            if (w_chg_done) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = CHANGE;
            end
         end
         default: begin
            w_state_next  = IDLE;
            w_credit_next = {CREDIT_W{1'b0}};
         end
      endcase
   end

   // State, credit and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_credit   <= {CREDIT_W{1'b0}};
         r_item     <= {SEL_W{1'b0}};
         r_bev      <= 1'b0;
         r_coin_rej <= 1'b0;
         r_deny     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_credit   <= w_credit_next;
         r_item     <= w_item_next;
         r_bev      <= w_bev;
         r_coin_rej <= w_coin_rej;
         r_deny     <= w_deny;
      end
   end

   vending_change #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .clk           (clk),
      .reset         (reset),
      .i_active      (w_chg_active),
      .i_credit      (r_credit),
      .o_credit_next (w_chg_credit),
      .o_done        (w_chg_done),
      .o_chg_one     (bus.chg_one),
      .o_chg_half    (bus.chg_half)
   );

`ifdef VENDING_STOCK_EN
   localparam int STOCK_W = $clog2(STOCK_INIT + 1);

   logic [STOCK_W-1:0]   r_stock      [NUM_ITEMS];
   logic [STOCK_W-1:0]   w_stock_next [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] r_sold_out;

   // Restock overrides a coincident vend decrement
   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (bus.restock) begin
            w_stock_next[i] = STOCK_W'(STOCK_INIT);
         end else if (w_vend_ok && (int'(bus.sel) == i)) begin
            w_stock_next[i] = r_stock[i] - STOCK_W'(1);
         end else begin
            w_stock_next[i] = r_stock[i];
         end
      end
   end

   // Stock counters and their empty flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            r_stock[i] <= STOCK_W'(STOCK_INIT);
         end
         r_sold_out <= {NUM_ITEMS{1'b0}};
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            r_stock[i]    <= w_stock_next[i];
            r_sold_out[i] <= (w_stock_next[i] == {STOCK_W{1'b0}});
         end
      end
   end

   assign w_sold_out = r_sold_out;
   assign w_sel_sold = w_sel_in_range ? r_sold_out[bus.sel] : 1'b1;
`else
   localparam int unused_stock_init = STOCK_INIT;
   logic w_unused_restock;

   assign w_unused_restock = bus.restock;
   assign w_sold_out       = {NUM_ITEMS{1'b0}};
   assign w_sel_sold       = 1'b0;
`endif

   assign bus.bev      = r_bev;
   assign bus.item     = r_item;
   assign bus.bal      = r_credit;
   assign bus.coin_rej = r_coin_rej;
   assign bus.deny     = r_deny;
   assign bus.sold_out = w_sold_out;

endmodule
